// File: rtl/shift_ring_counter.sv
// Parametrised ring / Johnson shift counter with direction, enable, load, wrap pulse and illegal-state flag.
// Define SRC_SELF_CORRECT_EN to make an enabled step from an illegal state return to home.
module shift_ring_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned HOME_POS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             err
);

   typedef enum logic {
      MODE_RING    = 1'b0,
      MODE_JOHNSON = 1'b1
   } mode_e;

   mode_e            mode_in, mode_q, mode_d;
   logic [WIDTH-1:0] q_q, q_d, shifted, home_q;
   logic             tc_q, tc_d, legal;

   function automatic logic [WIDTH-1:0] home_of(input mode_e m);
      logic [WIDTH-1:0] h;
      h = '0;
      if (m == MODE_RING) h = {{(WIDTH-1){1'b0}}, 1'b1} << HOME_POS;
      return h;
   endfunction

   // Johnson legality: at most one 0/1 boundary between adjacent bits.
   function automatic logic is_legal(input mode_e m, input logic [WIDTH-1:0] v);
      int unsigned edges;
      edges = 0;
      for (int unsigned i = 0; i < WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) edges++;
      end
      if (m == MODE_RING) return ($countones(v) == 1);
      return (edges <= 1);
   endfunction

   assign mode_in = mode_e'(mode);
   assign home_q  = home_of(mode_q);
   assign legal   = is_legal(mode_q, q_q);

   always_comb begin
      shifted = q_q;
      if (mode_q == MODE_RING) begin
         if (dir) shifted = {q_q[0], q_q[WIDTH-1:1]};
         else     shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      end else begin
         if (dir) shifted = {~q_q[0], q_q[WIDTH-1:1]};
         else     shifted = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      end
   end

   always_comb begin
      mode_d = mode_q;
      q_d    = q_q;
      tc_d   = 1'b0;
      if (mode_in != mode_q) begin
         mode_d = mode_in;
         q_d    = home_of(mode_in);
      end else if (load) begin
         q_d = load_val;
      end else if (en) begin
`ifdef SRC_SELF_CORRECT_EN
         if (!legal) begin
            q_d = home_q;
         end else begin
            q_d  = shifted;
            tc_d = (shifted == home_q);
         end
`else
         q_d  = shifted;
         tc_d = legal && (shifted == home_q);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= mode_in;
         q_q    <= home_of(mode_in);
         tc_q   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         q_q    <= q_d;
         tc_q   <= tc_d;
      end
   end

   assign q   = q_q;
   assign tc  = tc_q;
   assign err = !legal;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Self-checking bench for shift_ring_counter (WIDTH=4, HOME_POS=0): directed sequences plus randomized run
// against a phase/arithmetic reference model.
module tb_shift_ring_counter;

   localparam int unsigned W  = 4;
   localparam int unsigned HP = 0;
   localparam int unsigned M  = 2 ** W;

   logic         clk = 1'b0;
   logic         rst, en, dir, mode, load;
   logic [W-1:0] load_val, q;
   logic         tc, err;

   int unsigned total = 0;
   int unsigned bad   = 0;

   int unsigned m_q   = 0;
   bit          m_mode = 1'b0;
   bit          m_tc   = 1'b0;

   shift_ring_counter #(.WIDTH(W), .HOME_POS(HP)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int unsigned home_of(input bit m);
      return m ? 0 : (1 << HP);
   endfunction

   // k-th Johnson phase: k ones filling from the LSB, then zeros filling from the LSB.
   function automatic int unsigned jpat(input int unsigned k);
      if (k <= W) return (2 ** k) - 1;
      return (M - 1) - ((2 ** (k - W)) - 1);
   endfunction

   function automatic bit legal_of(input bit m, input int unsigned v);
      if (!m) return ($countones(v) == 1);
      for (int unsigned k = 0; k < 2 * W; k++) if (v == jpat(k)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int unsigned step_of(input bit m, input bit d, input int unsigned v);
      int unsigned top, low;
      top = v / (M / 2);
      low = v % 2;
      if (!m) return d ? (v / 2 + low * (M / 2)) : ((v * 2) % M + top);
      return d ? (v / 2 + (1 - low) * (M / 2)) : ((v * 2) % M + (1 - top));
   endfunction

   function automatic logic [W+1:0] expected();
      return {W'(m_q), m_tc, ~legal_of(m_mode, m_q)};
   endfunction

   task automatic drive(input bit r, input bit e, input bit d, input bit md,
                        input bit ld, input logic [W-1:0] lv);
      rst = r; en = e; dir = d; mode = md; load = ld; load_val = lv;
      @(posedge clk);
      if (r || md != m_mode) begin
         m_mode = md; m_q = home_of(md); m_tc = 1'b0;
      end else if (ld) begin
         m_q = lv; m_tc = 1'b0;
      end else if (e) begin
         if (legal_of(m_mode, m_q)) begin
            m_q  = step_of(m_mode, d, m_q);
            m_tc = (m_q == home_of(m_mode));
         end else begin
`ifdef SRC_SELF_CORRECT_EN
            m_q = home_of(m_mode);
`else
            m_q = step_of(m_mode, d, m_q);
`endif
            m_tc = 1'b0;
         end
      end else begin
         m_tc = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 1, 0, 0, 0, '0);
      total++;
      if ({q, tc, err} !== {4'b0001, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset q/tc/err=%b exp=%b", {q, tc, err}, {4'b0001, 2'b00});
      end
   endtask

   task automatic test_ring_up();
      logic [W-1:0] s [4];
      s = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, 0, '0);
         total++;
         if ({q, tc, err} !== {s[i], i == 3, 1'b0}) begin
            bad++; $display("FAIL ring_up[%0d] q/tc/err=%b exp=%b", i, {q, tc, err}, {s[i], i == 3, 1'b0});
         end
      end
   endtask

   task automatic test_johnson();
      logic [W-1:0] s [9];
      s = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 0, 1, 0, '0);
         total++;
         if ({q, tc, err} !== {s[i], i == 8, 1'b0}) begin
            bad++; $display("FAIL johnson[%0d] q/tc/err=%b exp=%b", i, {q, tc, err}, {s[i], i == 8, 1'b0});
         end
      end
   endtask

   task automatic test_dir();
      logic [W-1:0] s [4];
      bit           d [4];
      s = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
      d = '{1'b1, 1'b1, 1'b0, 1'b1};
      drive(0, 1, 0, 0, 0, '0);
      drive(0, 1, 0, 0, 1, 4'b0100);
      total++;
      if (q !== 4'b0100) begin
         bad++; $display("FAIL dir_load q=%b exp=0100", q);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, d[i], 0, 0, '0);
         total++;
         if ({q, tc, err} !== {s[i], s[i] == 4'b0001, 1'b0}) begin
            bad++; $display("FAIL dir[%0d] q/tc/err=%b exp=%b", i, {q, tc, err}, {s[i], s[i] == 4'b0001, 1'b0});
         end
      end
   endtask

   task automatic test_load_illegal();
      logic [W+1:0] exp;
      drive(0, 1, 0, 0, 1, 4'b0101);
      total++;
      if ({q, tc, err} !== {4'b0101, 1'b0, 1'b1}) begin
         bad++; $display("FAIL load_illegal q/tc/err=%b exp=%b", {q, tc, err}, {4'b0101, 2'b01});
      end
`ifdef SRC_SELF_CORRECT_EN
      exp = {4'b0001, 1'b0, 1'b0};
`else
      exp = {4'b1010, 1'b0, 1'b1};
`endif
      drive(0, 1, 0, 0, 0, '0);
      total++;
      if ({q, tc, err} !== exp) begin
         bad++; $display("FAIL illegal_step q/tc/err=%b exp=%b", {q, tc, err}, exp);
      end
      drive(0, 0, 0, 0, 1, 4'b0001);
   endtask

   task automatic test_mode_rst();
      drive(0, 0, 0, 0, 1, 4'b0100);
      drive(0, 1, 0, 1, 0, '0);
      total++;
      if ({q, tc, err} !== {4'b0000, 1'b0, 1'b0}) begin
         bad++; $display("FAIL mode_flip q/tc/err=%b exp=%b", {q, tc, err}, {4'b0000, 2'b00});
      end
      drive(0, 1, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, '0);
      total++;
      if (q !== 4'b1000) begin
         bad++; $display("FAIL pre_rst q=%b exp=1000", q);
      end
      drive(1, 1, 0, 0, 0, '0);
      total++;
      if ({q, tc, err} !== {4'b0001, 1'b0, 1'b0}) begin
         bad++; $display("FAIL mid_rst q/tc/err=%b exp=%b", {q, tc, err}, {4'b0001, 2'b00});
      end
   endtask

   task automatic test_hold();
      drive(0, 1, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, i[0], 0, 0, '0);
         total++;
         if ({q, tc, err} !== {4'b0010, 1'b0, 1'b0}) begin
            bad++; $display("FAIL hold[%0d] q/tc/err=%b exp=%b", i, {q, tc, err}, {4'b0010, 2'b00});
         end
      end
      drive(0, 0, 0, 0, 1, 4'b1000);
      drive(0, 1, 0, 0, 1, 4'b0001);
      total++;
      if ({q, tc, err} !== {4'b0001, 1'b0, 1'b0}) begin
         bad++; $display("FAIL load_home q/tc/err=%b exp=%b", {q, tc, err}, {4'b0001, 2'b00});
      end
   endtask

   task automatic test_random();
      bit md;
      md = m_mode;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) md = ~md;
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
               md, $urandom_range(0, 7) == 0, W'($urandom));
         total++;
         if ({q, tc, err} !== expected()) begin
            bad++; $display("FAIL random[%0d] q/tc/err=%b exp=%b", i, {q, tc, err}, expected());
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
      test_reset();
      test_ring_up();
      test_johnson();
      test_dir();
      test_load_illegal();
      test_mode_rst();
      test_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
